// File: rtl/divider_pipe_sched_if.sv
// Request/result handshake bundle for the two requesters of divider_pipe_sched.
// DIVIDER_DBZ_FLAG_EN adds the per-requester divide-by-zero result flags.
interface divider_pipe_sched_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [7:0]  req0_dividend;
  logic [19:0] req0_divisor;
  logic        req1_valid;
  logic        req1_ready;
  logic [7:0]  req1_dividend;
  logic [19:0] req1_divisor;

  logic        res0_valid;
  logic        res0_ready;
  logic [7:0]  res0_quotient;
  logic [19:0] res0_remainder;
  logic        res1_valid;
  logic        res1_ready;
  logic [7:0]  res1_quotient;
  logic [19:0] res1_remainder;
`ifdef DIVIDER_DBZ_FLAG_EN
  logic        res0_dbz;
  logic        res1_dbz;
`endif

  modport master (
    output req0_valid, req0_dividend, req0_divisor,
    output req1_valid, req1_dividend, req1_divisor,
    output res0_ready, res1_ready,
    input  req0_ready, req1_ready,
    input  res0_valid, res0_quotient, res0_remainder,
    input  res1_valid, res1_quotient, res1_remainder
`ifdef DIVIDER_DBZ_FLAG_EN
    , input res0_dbz, res1_dbz
`endif
  );

  modport slave (
    input  req0_valid, req0_dividend, req0_divisor,
    input  req1_valid, req1_dividend, req1_divisor,
    input  res0_ready, res1_ready,
    output req0_ready, req1_ready,
    output res0_valid, res0_quotient, res0_remainder,
    output res1_valid, res1_quotient, res1_remainder
`ifdef DIVIDER_DBZ_FLAG_EN
    , output res0_dbz, res1_dbz
`endif
  );
endinterface

// File: rtl/divider_pipe_sched.sv
// Two-requester scheduler for an untagged PIPE_DEPTH-stage divider with per-requester result FIFOs.
// Optional macro DIVIDER_DBZ_FLAG_EN: flags zero-divisor results (quotient FF, remainder = dividend).
module divider_pipe_sched #(
  parameter int PIPE_DEPTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  divider_pipe_sched_if.slave bus,
  output logic                pipe_start,
  output logic [27:0]         pipe_divided,
  output logic [19:0]         pipe_divisor,
  input  logic                pipe_start_out,
  input  logic [27:0]         pipe_result,
  input  logic [7:0]          pipe_q,
  output logic                err
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] CREDITS  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic       valid;
    logic       owner;
`ifdef DIVIDER_DBZ_FLAG_EN
    logic       dbz;
    logic [7:0] dividend;
`endif
  } tag_t;

  typedef struct packed {
    logic [7:0]  quotient;
    logic [19:0] remainder;
`ifdef DIVIDER_DBZ_FLAG_EN
    logic        dbz;
`endif
  } entry_t;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  logic [1:0]  w_req_valid, w_res_ready, w_res_valid;
  logic [1:0]  w_elig, w_ready, w_acc, w_pop, w_push;
  logic [7:0]  w_dividend [2];
  logic [19:0] w_divisor [2];
  logic        w_issue, w_owner, w_mismatch, w_capture, w_unused_bits;
  tag_t        w_tag_in, w_tail;
  entry_t      w_entry;
  entry_t      w_head [2];

  logic          r_rr;
  logic          r_pipe_start;
  logic [27:0]   r_pipe_divided;
  logic [19:0]   r_pipe_divisor;
  logic          r_err;
  logic [CW-1:0] r_cnt [2];
  logic [CW-1:0] r_occ [2];
  logic [PW-1:0] r_wp [2];
  logic [PW-1:0] r_rp [2];
  tag_t          r_tag [PIPE_DEPTH+1];
  entry_t        r_mem [2][FIFO_DEPTH];

  assign w_req_valid   = {bus.req1_valid, bus.req0_valid};
  assign w_res_ready   = {bus.res1_ready, bus.res0_ready};
  assign w_dividend[0] = bus.req0_dividend;
  assign w_dividend[1] = bus.req1_dividend;
  assign w_divisor[0]  = bus.req0_divisor;
  assign w_divisor[1]  = bus.req1_divisor;

  // cnt counts in-flight plus queued results, so a grant can never overflow its FIFO.
  assign w_elig     = {r_cnt[1] < CREDITS, r_cnt[0] < CREDITS};
  assign w_ready[0] = w_elig[0] && (!r_rr || !(w_req_valid[1] && w_elig[1]));
  assign w_ready[1] = w_elig[1] && ( r_rr || !(w_req_valid[0] && w_elig[0]));
  assign w_acc      = w_req_valid & w_ready;
  assign w_issue    = |w_acc;
  assign w_owner    = w_acc[1];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pipe_start   <= 1'b0;
      r_pipe_divided <= '0;
      r_pipe_divisor <= '0;
      r_rr           <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_pipe_start   <= w_issue;
      r_pipe_divided <= w_issue ? {20'd0, w_dividend[w_owner]} : '0;
      r_pipe_divisor <= w_issue ? ~w_divisor[w_owner] : '0;
      if (w_issue) r_rr <= ~w_owner;
      r_err          <= r_err | w_mismatch;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it holding a value (latch).
  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_issue;
    w_tag_in.owner = w_owner;
`ifdef DIVIDER_DBZ_FLAG_EN
    if (w_issue && (w_divisor[w_owner] == 20'd0)) begin
      w_tag_in.dbz      = 1'b1;
      w_tag_in.dividend = w_dividend[w_owner];
    end
`endif
  end

  // Entry 0 lines up with pipe_start; entry PIPE_DEPTH lines up with pipe_start_out.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= PIPE_DEPTH; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i <= PIPE_DEPTH; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_tail        = r_tag[PIPE_DEPTH];
  assign w_mismatch    = pipe_start_out != w_tail.valid;
  assign w_capture     = pipe_start_out && w_tail.valid;
  assign w_push        = {w_capture && w_tail.owner, w_capture && !w_tail.owner};
  assign w_unused_bits = ^pipe_result[7:0];

  always_comb begin
    w_entry           = '0;
    w_entry.quotient  = pipe_q;
    w_entry.remainder = pipe_result[27:8];
`ifdef DIVIDER_DBZ_FLAG_EN
    if (w_tail.dbz) begin
      w_entry.quotient  = 8'hFF;
      w_entry.remainder = {12'd0, w_tail.dividend};
      w_entry.dbz       = 1'b1;
    end
`endif
  end

  always_comb begin
    for (int i = 0; i < 2; i++) w_res_valid[i] = r_occ[i] != '0;
  end
  assign w_pop = w_res_valid & w_res_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= '0;
        r_occ[i] <= '0;
        r_wp[i]  <= '0;
        r_rp[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case ({w_acc[i], w_pop[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + CW'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - CW'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
        case ({w_push[i], w_pop[i]})
          2'b10:   r_occ[i] <= r_occ[i] + CW'(1);
          2'b01:   r_occ[i] <= r_occ[i] - CW'(1);
          default: r_occ[i] <= r_occ[i];
        endcase
        if (w_push[i]) r_wp[i] <= next_ptr(r_wp[i]);
        if (w_pop[i])  r_rp[i] <= next_ptr(r_rp[i]);
      end
    end
  end

  // NOTE: FIFO storage has no reset; the head is masked by valid, so only pointers and counts need one.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (w_push[i]) r_mem[i][r_wp[i]] <= w_entry;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) w_head[i] = w_res_valid[i] ? r_mem[i][r_rp[i]] : '0;
  end

  assign bus.req0_ready     = w_ready[0];
  assign bus.req1_ready     = w_ready[1];
  assign bus.res0_valid     = w_res_valid[0];
  assign bus.res1_valid     = w_res_valid[1];
  assign bus.res0_quotient  = w_head[0].quotient;
  assign bus.res1_quotient  = w_head[1].quotient;
  assign bus.res0_remainder = w_head[0].remainder;
  assign bus.res1_remainder = w_head[1].remainder;
`ifdef DIVIDER_DBZ_FLAG_EN
  assign bus.res0_dbz       = w_head[0].dbz;
  assign bus.res1_dbz       = w_head[1].dbz;
`endif

  assign pipe_start   = r_pipe_start;
  assign pipe_divided = r_pipe_divided;
  assign pipe_divisor = r_pipe_divisor;
  assign err          = r_err;
endmodule

// File: tb/tb_divider_pipe_sched.sv
// Directed bench for divider_pipe_sched with a behavioural 8-stage divider pipeline model.
// Builds with or without DIVIDER_DBZ_FLAG_EN; the zero-divisor step runs only when it is defined.
module tb_divider_pipe_sched;
  localparam int PD = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        pipe_start;
  logic [27:0] pipe_divided;
  logic [19:0] pipe_divisor;
  logic        pipe_start_out;
  logic [27:0] pipe_result;
  logic [7:0]  pipe_q;
  logic        err;
  logic        force_sout;

  int checks = 0;
  int errors = 0;
  int lat0, lat1, acc_cnt, pop0, pop1;
  logic        saw_other, saw_bad;
  logic [7:0]  q0, q1;
  logic [19:0] r0, r1;
  logic        dbz1;

  divider_pipe_sched_if bus ();

  divider_pipe_sched #(.PIPE_DEPTH(PD), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .pipe_start(pipe_start), .pipe_divided(pipe_divided), .pipe_divisor(pipe_divisor),
    .pipe_start_out(pipe_start_out), .pipe_result(pipe_result), .pipe_q(pipe_q), .err(err)
  );

  always #5 clock = ~clock;

  // Pipeline model: pipe_start in cycle t gives pipe_start_out in cycle t+PD.
  logic [PD-1:0] m_v;
  logic [7:0]    m_q [PD];
  logic [19:0]   m_r [PD];
  logic [19:0]   m_d;
  logic [19:0]   m_n;
  assign m_d = ~pipe_divisor;
  assign m_n = {12'd0, pipe_divided[7:0]};

  always @(posedge clock) begin
    if (reset) begin
      m_v <= '0;
    end else begin
      m_v    <= {m_v[PD-2:0], pipe_start};
      m_q[0] <= (m_d == 20'd0) ? 8'hFF : 8'(m_n / m_d);
      m_r[0] <= (m_d == 20'd0) ? m_n : (m_n % m_d);
      for (int i = 1; i < PD; i++) begin
        m_q[i] <= m_q[i-1];
        m_r[i] <= m_r[i-1];
      end
    end
  end

  assign pipe_start_out = m_v[PD-1] | force_sout;
  assign pipe_q         = m_q[PD-1];
  assign pipe_result    = {m_r[PD-1], m_q[PD-1]};

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    force_sout = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_dividend = '0; bus.req0_divisor = '0;
    bus.req1_valid = 1'b0; bus.req1_dividend = '0; bus.req1_divisor = '0;
    bus.res0_ready = 1'b0; bus.res1_ready = 1'b0;
    tick();
    tick();

    // Reset state and rr favouring requester 0
    check("rst_pipe_start", 32'(pipe_start), 32'd0);
    check("rst_divided", 32'(pipe_divided), 32'd0);
    check("rst_divisor", 32'(pipe_divisor), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_res0_valid", 32'(bus.res0_valid), 32'd0);
    check("rst_res1_valid", 32'(bus.res1_valid), 32'd0);
    check("rst_res0_quot", 32'(bus.res0_quotient), 32'd0);
    check("rst_res0_rem", 32'(bus.res0_remainder), 32'd0);
`ifdef DIVIDER_DBZ_FLAG_EN
    check("rst_res0_dbz", 32'(bus.res0_dbz), 32'd0);
`endif
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    check("rst_rr_ready0", 32'(bus.req0_ready), 32'd1);
    check("rst_rr_ready1", 32'(bus.req1_ready), 32'd0);

    // Single 100/7 on requester 0
    reset = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_dividend = 8'd100; bus.req0_divisor = 20'd7;
    bus.res0_ready = 1'b1; bus.res1_ready = 1'b1;
    #1;
    check("t1_ready0", 32'(bus.req0_ready), 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    check("t1_pipe_start", 32'(pipe_start), 32'd1);
    check("t1_divided", 32'(pipe_divided), 32'd100);
    check("t1_divisor", 32'(pipe_divisor), 32'hFFFF8);
    lat0 = -1; saw_other = 1'b0; q0 = '0; r0 = '0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 2) begin
        check("t1_idle_start", 32'(pipe_start), 32'd0);
        check("t1_idle_divided", 32'(pipe_divided), 32'd0);
        check("t1_idle_divisor", 32'(pipe_divisor), 32'd0);
      end
      if (bus.res0_valid && lat0 < 0) begin
        lat0 = k; q0 = bus.res0_quotient; r0 = bus.res0_remainder;
      end
      if (bus.res1_valid) saw_other = 1'b1;
      tick();
    end
    check("t1_latency", 32'(lat0), 32'd10);
    check("t1_quotient", 32'(q0), 32'd14);
    check("t1_remainder", 32'(r0), 32'd2);
    check("t1_res1_quiet", 32'(saw_other), 32'd0);
    check("t1_popped", 32'(bus.res0_valid), 32'd0);

    // Both requesters streaming: grants alternate starting with 0
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_dividend = 8'd50; bus.req0_divisor = 20'd5;
    bus.req1_valid = 1'b1; bus.req1_dividend = 8'd60; bus.req1_divisor = 20'd6;
    #1;
    pop0 = 0; pop1 = 0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t2_grant0_c%0d", k), 32'(bus.req0_ready), 32'((k % 2) == 0));
      check($sformatf("t2_grant1_c%0d", k), 32'(bus.req1_ready), 32'((k % 2) == 1));
      if (k >= 1) check($sformatf("t2_start_c%0d", k), 32'(pipe_start), 32'd1);
      tick();
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    check("t2_start_last", 32'(pipe_start), 32'd1);
    for (int k = 0; k < 20; k++) begin
      if (bus.res0_valid) begin
        pop0++;
        check("t2_q0", 32'(bus.res0_quotient), 32'd10);
      end
      if (bus.res1_valid) begin
        pop1++;
        check("t2_q1", 32'(bus.res1_quotient), 32'd10);
      end
      tick();
    end
    check("t2_pops0", 32'(pop0), 32'd3);
    check("t2_pops1", 32'(pop1), 32'd3);
    check("t2_err", 32'(err), 32'd0);

    // Credit limit: consumer 0 stalled, five requests offered
    do_reset();
    bus.res0_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_dividend = 8'd10; bus.req0_divisor = 20'd1;
    #1;
    acc_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (bus.req0_ready) begin
        acc_cnt++;
        tick();
        if (acc_cnt < 5) bus.req0_dividend = bus.req0_dividend + 8'd1;
      end else begin
        tick();
      end
    end
    check("t3_accepts", 32'(acc_cnt), 32'd4);
    check("t3_ready_low", 32'(bus.req0_ready), 32'd0);
    check("t3_full_valid", 32'(bus.res0_valid), 32'd1);
    bus.res0_ready = 1'b1;
    #1;
    check("t3_pop_q10", 32'(bus.res0_quotient), 32'd10);
    check("t3_ready_at_pop", 32'(bus.req0_ready), 32'd0);
    tick();
    check("t3_ready_after_pop", 32'(bus.req0_ready), 32'd1);
    bus.req0_valid = 1'b0;
    check("t3_pop_q11", 32'(bus.res0_quotient), 32'd11);
    check("t3_pop_r11", 32'(bus.res0_remainder), 32'd0);
    tick();
    check("t3_pop_q12", 32'(bus.res0_quotient), 32'd12);
    tick();
    check("t3_pop_q13", 32'(bus.res0_quotient), 32'd13);
    tick();
    check("t3_drained", 32'(bus.res0_valid), 32'd0);

    // Interleave 200/3 on requester 0 and 255/16 on requester 1
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_dividend = 8'd200; bus.req0_divisor = 20'd3;
    bus.req1_valid = 1'b1; bus.req1_dividend = 8'd255; bus.req1_divisor = 20'd16;
    #1;
    check("t4_ready0", 32'(bus.req0_ready), 32'd1);
    check("t4_ready1_wait", 32'(bus.req1_ready), 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    check("t4_ready1", 32'(bus.req1_ready), 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    lat0 = -1; lat1 = -1;
    for (int k = 2; k <= 20; k++) begin
      if (bus.res0_valid && lat0 < 0) begin
        lat0 = k; q0 = bus.res0_quotient; r0 = bus.res0_remainder;
      end
      if (bus.res1_valid && lat1 < 0) begin
        lat1 = k; q1 = bus.res1_quotient; r1 = bus.res1_remainder;
`ifdef DIVIDER_DBZ_FLAG_EN
        check("t4_dbz1_clear", 32'(bus.res1_dbz), 32'd0);
`endif
      end
      tick();
    end
    check("t4_lat0", 32'(lat0), 32'd10);
    check("t4_lat1", 32'(lat1), 32'd11);
    check("t4_q0", 32'(q0), 32'd66);
    check("t4_r0", 32'(r0), 32'd2);
    check("t4_q1", 32'(q1), 32'd15);
    check("t4_r1", 32'(r1), 32'd15);

    // Reset with three requests in flight
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_dividend = 8'd20; bus.req0_divisor = 20'd1;
    tick();
    tick();
    tick();
    bus.req0_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("t5_pipe_start", 32'(pipe_start), 32'd0);
    check("t5_divided", 32'(pipe_divided), 32'd0);
    check("t5_divisor", 32'(pipe_divisor), 32'd0);
    check("t5_res0_valid", 32'(bus.res0_valid), 32'd0);
    check("t5_res1_valid", 32'(bus.res1_valid), 32'd0);
    reset = 1'b0;
    saw_bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.res0_valid || bus.res1_valid || err) saw_bad = 1'b1;
      tick();
    end
    check("t5_no_stale_results", 32'(saw_bad), 32'd0);
    check("t5_err", 32'(err), 32'd0);

    // Spurious pipe_start_out with an empty tag tail
    force_sout = 1'b1;
    tick();
    force_sout = 1'b0;
    check("t6_err_set", 32'(err), 32'd1);
    check("t6_discard0", 32'(bus.res0_valid), 32'd0);
    check("t6_discard1", 32'(bus.res1_valid), 32'd0);
    tick();
    tick();
    tick();
    check("t6_err_sticky", 32'(err), 32'd1);
    do_reset();
    check("t6_err_cleared", 32'(err), 32'd0);

`ifdef DIVIDER_DBZ_FLAG_EN
    // Zero divisor on requester 1
    bus.req1_valid = 1'b1; bus.req1_dividend = 8'd37; bus.req1_divisor = 20'd0;
    #1;
    check("t7_ready1", 32'(bus.req1_ready), 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    lat1 = -1; dbz1 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.res1_valid && lat1 < 0) begin
        lat1 = k; q1 = bus.res1_quotient; r1 = bus.res1_remainder; dbz1 = bus.res1_dbz;
      end
      tick();
    end
    check("t7_lat", 32'(lat1), 32'd10);
    check("t7_quotient", 32'(q1), 32'hFF);
    check("t7_remainder", 32'(r1), 32'd37);
    check("t7_dbz", 32'(dbz1), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
